// File: rtl/voice_divider_bank.sv
// Eight square-wave tone generators sharing a prescaled tick, with a registered
// popcount mix. Divider changes are taken only at half-period boundaries or while muted.
module voice_divider_bank #(
  parameter int D_W      = 16,
  parameter int PRESCALE = 4,
  parameter int MIX_W    = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [D_W-1:0]   VOICE_0_DIV,
  input  logic [D_W-1:0]   VOICE_1_DIV,
  input  logic [D_W-1:0]   VOICE_2_DIV,
  input  logic [D_W-1:0]   VOICE_3_DIV,
  input  logic [D_W-1:0]   VOICE_4_DIV,
  input  logic [D_W-1:0]   VOICE_5_DIV,
  input  logic [D_W-1:0]   VOICE_6_DIV,
  input  logic [D_W-1:0]   VOICE_7_DIV,
  output logic [7:0]       voice_sq,
  output logic [7:0]       voice_active,
  output logic [MIX_W-1:0] mix_out,
  output logic             mix_valid
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [D_W-1:0]   div_in [8];
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [D_W-1:0]   cnt_q [8];
  logic [D_W-1:0]   cnt_d [8];
  logic [D_W-1:0]   div_q [8];
  logic [D_W-1:0]   div_d [8];
  logic [7:0]       sq_q, sq_d;
  logic             tick_q, tick_d;
  logic [MIX_W-1:0] mix_q, mix_d;
  logic             mix_valid_q, mix_valid_d;

  assign div_in[0] = VOICE_0_DIV;
  assign div_in[1] = VOICE_1_DIV;
  assign div_in[2] = VOICE_2_DIV;
  assign div_in[3] = VOICE_3_DIV;
  assign div_in[4] = VOICE_4_DIV;
  assign div_in[5] = VOICE_5_DIV;
  assign div_in[6] = VOICE_6_DIV;
  assign div_in[7] = VOICE_7_DIV;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  // A voice only reloads its divider when muted or at the end of a half-period,
  // so a mid-period write never shortens or stretches the current level.
  always_comb begin
    sq_d = sq_q;
    for (int n = 0; n < 8; n++) begin
      cnt_d[n] = cnt_q[n];
      div_d[n] = div_q[n];
      if (tick) begin
        if (div_q[n] == '0) begin
          cnt_d[n] = '0;
          sq_d[n]  = 1'b0;
          div_d[n] = div_in[n];
        end else if (cnt_q[n] == div_q[n] - D_W'(1)) begin
          cnt_d[n] = '0;
          sq_d[n]  = ~sq_q[n];
          div_d[n] = div_in[n];
        end else begin
          cnt_d[n] = cnt_q[n] + D_W'(1);
        end
      end
    end
  end

  // mix_out lags voice_sq by one cycle, so the valid strobe needs two stages of tick.
  always_comb begin
    mix_d = '0;
    for (int n = 0; n < 8; n++) begin
      mix_d = mix_d + MIX_W'(sq_q[n]);
    end
    tick_d      = tick;
    mix_valid_d = tick_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_q       <= '0;
      sq_q        <= '0;
      tick_q      <= 1'b0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        cnt_q[n] <= '0;
        div_q[n] <= '0;
      end
    end else begin
      pre_q       <= pre_d;
      sq_q        <= sq_d;
      tick_q      <= tick_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      for (int n = 0; n < 8; n++) begin
        cnt_q[n] <= cnt_d[n];
        div_q[n] <= div_d[n];
      end
    end
  end

  always_comb begin
    voice_active = '0;
    for (int n = 0; n < 8; n++) begin
      voice_active[n] = (div_q[n] != '0);
    end
  end

  assign voice_sq  = sq_q;
  assign mix_out   = mix_q;
  assign mix_valid = mix_valid_q;

endmodule

// File: tb/tb_voice_divider_bank.sv
// Bench for voice_divider_bank: behavioural tick/half-period model compared every cycle,
// plus hand-computed timing points on a PRESCALE=4 and a PRESCALE=1 instance.
module tb_voice_divider_bank;

  localparam int PRESCALE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic [15:0] vin [8];
  logic [15:0] vin2 [8];
  logic [7:0]  voice_sq, voice_active, voice_sq2, voice_active2;
  logic [3:0]  mix_out, mix_out2;
  logic        mix_valid, mix_valid2;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  voice_divider_bank #(.D_W(16), .PRESCALE(PRESCALE), .MIX_W(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .VOICE_0_DIV(vin[0]), .VOICE_1_DIV(vin[1]), .VOICE_2_DIV(vin[2]), .VOICE_3_DIV(vin[3]),
    .VOICE_4_DIV(vin[4]), .VOICE_5_DIV(vin[5]), .VOICE_6_DIV(vin[6]), .VOICE_7_DIV(vin[7]),
    .voice_sq(voice_sq), .voice_active(voice_active), .mix_out(mix_out), .mix_valid(mix_valid)
  );

  voice_divider_bank #(.D_W(16), .PRESCALE(1), .MIX_W(4)) dut_fast (
    .sys_clk(clk), .sys_rst_n(rst2_n),
    .VOICE_0_DIV(vin2[0]), .VOICE_1_DIV(vin2[1]), .VOICE_2_DIV(vin2[2]), .VOICE_3_DIV(vin2[3]),
    .VOICE_4_DIV(vin2[4]), .VOICE_5_DIV(vin2[5]), .VOICE_6_DIV(vin2[6]), .VOICE_7_DIV(vin2[7]),
    .voice_sq(voice_sq2), .voice_active(voice_active2), .mix_out(mix_out2), .mix_valid(mix_valid2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a voice counts ticks elapsed in its half-period and flips when
  // that count reaches its divider; a zero divider means muted and re-reads the input.
  int       m_pre = 0;
  int       m_div [8];
  int       m_el [8];
  bit [7:0] m_sq = '0;
  int       m_mix = 0;
  bit       m_tq = 1'b0;
  bit       m_valid = 1'b0;
  bit       m_tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre = 0; m_sq = '0; m_mix = 0; m_tq = 1'b0; m_valid = 1'b0;
      for (int n = 0; n < 8; n++) begin m_div[n] = 0; m_el[n] = 0; end
    end else begin
      m_tk    = (m_pre == PRESCALE - 1);
      m_mix   = $countones(m_sq);
      m_valid = m_tq;
      m_tq    = m_tk;
      if (m_tk) begin
        for (int n = 0; n < 8; n++) begin
          if (m_div[n] == 0) begin
            m_sq[n] = 1'b0; m_el[n] = 0; m_div[n] = int'(vin[n]);
          end else begin
            m_el[n]++;
            if (m_el[n] == m_div[n]) begin
              m_sq[n] = ~m_sq[n]; m_el[n] = 0; m_div[n] = int'(vin[n]);
            end
          end
        end
      end
      m_pre = (m_pre + 1) % PRESCALE;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [7:0] exp_act;
      for (int n = 0; n < 8; n++) exp_act[n] = (m_div[n] != 0);
      check("voice_sq",     32'(voice_sq),     32'(m_sq));
      check("voice_active", 32'(voice_active), 32'(exp_act));
      check("mix_out",      32'(mix_out),      32'(m_mix));
      check("mix_valid",    32'(mix_valid),    32'(m_valid));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_main();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
  endtask

  task automatic main_seq();
    for (int n = 0; n < 8; n++) vin[n] = 16'd0;
    vin[0] = 16'd3;
    repeat (3) @(posedge clk);
    reset_main();
    // single voice, div=3: load at tick 4, toggles at clk 16 and 28
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 3)  check("active0_before_tick", 32'(voice_active[0]), 32'd0);
      if (k == 4)  check("active0_at_tick", 32'(voice_active[0]), 32'd1);
      if (k == 15) check("sq0_before_toggle", 32'(voice_sq[0]), 32'd0);
      if (k == 16) check("sq0_first_toggle", 32'(voice_sq[0]), 32'd1);
      if (k == 17) check("mix_after_toggle", 32'(mix_out), 32'd1);
      if (k == 17) check("valid_after_toggle", 32'(mix_valid), 32'd1);
      if (k == 18) check("valid_one_cycle", 32'(mix_valid), 32'd0);
      if (k == 27) check("sq0_high_half", 32'(voice_sq[0]), 32'd1);
      if (k == 28) check("sq0_second_toggle", 32'(voice_sq[0]), 32'd0);
    end

    // all voices at div=4 loaded together: mix swings 0 <-> 8
    for (int n = 0; n < 8; n++) vin[n] = 16'd4;
    reset_main();
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 20) check("all_sq_high", 32'(voice_sq), 32'hFF);
      if (k == 21) check("mix_full_8", 32'(mix_out), 32'd8);
      if (k == 36) check("all_sq_low", 32'(voice_sq), 32'h00);
      if (k == 37) check("mix_back_0", 32'(mix_out), 32'd0);
    end

    // mid half-period retune of voice 1 and mute of voice 2
    for (int n = 0; n < 8; n++) vin[n] = 16'd0;
    vin[1] = 16'd10;
    vin[2] = 16'd5;
    reset_main();
    repeat (60) step();
    vin[1] = 16'd2;
    vin[2] = 16'd0;
    repeat (120) step();

    // randomized retunes, mutes and occasional mid-run resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        int v;
        v = $urandom_range(0, 7);
        vin[v] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 9));
      end
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
  endtask

  task automatic fast_seq();
    for (int n = 0; n < 8; n++) vin2[n] = 16'd0;
    vin2[3] = 16'd1;
    vin2[4] = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 1; k <= 65537; k++) begin
      step();
      if (k == 1) check("fast_active3_first_tick", 32'(voice_active2[3]), 32'd1);
      if (k == 1) check("fast_sq3_load", 32'(voice_sq2[3]), 32'd0);
      if (k >= 2 && k <= 9) check("fast_sq3_every_clk", 32'(voice_sq2[3]), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k == 2) check("fast_valid", 32'(mix_valid2), 32'd1);
      if (k == 3) check("fast_mix_1", 32'(mix_out2), 32'd1);
      if (k == 4) check("fast_mix_0", 32'(mix_out2), 32'd0);
      if (k == 2) check("fast_active4", 32'(voice_active2[4]), 32'd1);
      if (k == 65535) check("ffff_before_toggle", 32'(voice_sq2[4]), 32'd0);
      if (k == 65536) check("ffff_toggle", 32'(voice_sq2[4]), 32'd1);
    end
  endtask

  initial begin
    fork
      main_seq();
      fast_seq();
    join
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_divider_bank.md
Name: voice_divider_bank

Overview:
- Downstream consumer of the eight 16-bit voice divider registers written over SPI.
- Runs eight independent square-wave tone generators from a shared prescaled tick.
- Sums the voice outputs into a registered 4-bit mix level, with a valid strobe, for the audio output stage (PWM/DAC).
- Divider changes take effect only at half-period boundaries, so the outputs never glitch.

Parameters:
- D_W, 16: divider width; all VOICE_n_DIV inputs and the per-voice counters are this width.
- PRESCALE, 4: sys_clk cycles per oscillator tick. Must be ≥1; 1 means a tick every cycle.
- MIX_W, 4: mix output width. Must be ≥4 so that a count of 8 fits.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- VOICE_0_DIV .. VOICE_7_DIV  in  D_W each  half-period length in ticks; 0 = voice muted. Driven from sys_clk-domain registers.
- voice_sq  out  8  per-voice square output; bit n = voice n.
- voice_active  out  8  bit n = 1 when voice n's active (shadow) divider is nonzero.
- mix_out  out  MIX_W  number of voice_sq bits set (0..8), registered.
- mix_valid  out  1  one-cycle pulse marking a mix_out update that follows a tick.

Behaviour:
- Reset (asynchronous assert, synchronous release), all cleared to zero:
  - prescaler, all cnt, all active_div;
  - voice_sq = 0, voice_active = 0, mix_out = 0, mix_valid = 0.
- Prescaler:
  - pre counts 0..PRESCALE-1, then wraps to 0.
  - tick = (pre == PRESCALE-1), combinational.
  - With PRESCALE=1, tick is asserted every cycle.
- Per-voice state: active_div[D_W], cnt[D_W], sq. Nothing changes when tick=0. When tick=1:
  - Muted (active_div == 0): cnt←0, sq←0, active_div←VOICE_n_DIV.
  - Boundary (active_div != 0 and cnt == active_div-1): cnt←0, sq←~sq, active_div←VOICE_n_DIV.
  - Otherwise: cnt←cnt+1.
- Timing results:
  - Half-period = active_div ticks.
  - Output frequency = f_sys_clk / (2·PRESCALE·div).
  - div=1 toggles on every tick.
  - div=0xFFFF is legal; cnt never exceeds active_div-1, so the counter does not overflow.
- Divider updates:
  - VOICE_n_DIV is sampled only at a boundary tick or a muted tick; changes at any other time are ignored until then.
  - Multiple input changes between samples: the value present at the sampling tick wins.
- Unmute:
  - Input goes 0→X while muted: X loads at the next tick with sq=0, cnt=0.
  - The first toggle then occurs X ticks later.
- Mute:
  - Input goes X→0 while running: the current half-period completes and sq toggles at the boundary, where 0 is loaded.
  - At the next tick sq is forced to 0 and stays 0.
- voice_active[n] = (active_div_n != 0); it is a registered-state decode.
- Mix:
  - mix_out ← popcount(voice_sq), registered.
  - Latency: 1 cycle after voice_sq changes.
  - mix_valid ← tick registered, so it pulses in the same cycle that mix_out first reflects that tick's voice_sq update.
- Simultaneous events:
  - All voices update in parallel on the same tick; there is no arbitration.
  - An input change on the same cycle as a boundary tick is sampled (the new value is used).
- Reset mid-operation immediately clears all state. After release, voices restart as muted and reload their dividers on the first tick.

Test Plan:
- Reset: hold sys_rst_n=0 with VOICE_0_DIV=3, release → voice_sq=0 and mix_out=0 until the first tick. voice_active[0]=1 from the first tick (4th clk after release, PRESCALE=4).
- Basic tone: PRESCALE=4, VOICE_0_DIV=3, others 0 → voice_sq[0] toggles every 12 sys_clk (period 24). mix_out alternates 0/1 one cycle after each toggle. mix_valid pulses every 4 clk.
- Glitch-free change: voice 1 running at div=10; write div=2 mid half-period (cnt=4) → the current half-period still lasts 10 ticks, then half-periods are 2 ticks.
- Mute: voice 2 at div=5; set VOICE_2_DIV=0 → sq toggles at the pending boundary, is 0 one tick later, voice_active[2] falls at that boundary.
- Full mix: all eight dividers = 4 with identical load timing → voice_sq toggles between 0x00 and 0xFF; mix_out alternates 0 and 8 (no width overflow).
- Boundary/extreme: PRESCALE=1, VOICE_3_DIV=1 → voice_sq[3] toggles every clk. VOICE_4_DIV=0xFFFF → first toggle 65535 ticks after load, with no counter wrap.
